change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter INIT_COUNT, default 15: coins per denomination after reset or refill (4-bit counters).
REQ-002 Parameter GAP, default 1: idle low cycles between coin pulses (1..7).
REQ-003 Reset RST, synchronous, active-high; clock CLK.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 Start  input  1  request to dispense Amount; sampled only in IDLE.
REQ-007 Amount  input  7  change owed in 5-cent units (0..127).
REQ-008 Refill  input  1  reload all inventory counters to INIT_COUNT; honoured only in IDLE.
REQ-009 OneDollar, FiftyCents, TenCents, FiveCents  output  1 each  one-cycle coin-eject pulses (20, 10, 2, 1 units).
REQ-010 Busy  output  1  high in every state except IDLE.
REQ-011 Done  output  1  one-cycle pulse when a request finishes.
REQ-012 Shortfall  output  1  last request could not be fully paid.
REQ-013 Residual  output  7  undispensed units of last request.

Function
REQ-014 FSM states: IDLE, SELECT, PULSE, GAP, DONE; all outputs registered.
REQ-015 IDLE: Start=1 -> latch Amount into 7-bit remaining, clear Shortfall/Residual, go SELECT.
REQ-016 IDLE: Refill=1 with Start=0 -> all counters = INIT_COUNT, stay IDLE; Start and Refill together -> Start wins, Refill dropped.
REQ-017 SELECT: remaining=0 -> DONE; else pick largest value <= remaining with count>0 (order 20,10,2,1) -> PULSE; none eligible -> DONE with Shortfall=1, Residual=remaining.
REQ-018 PULSE: chosen output high exactly one cycle; remaining -= value; that count -= 1; next GAP.
REQ-019 GAP: all coin outputs low for GAP cycles, then SELECT.
REQ-020 At most one coin output high in any cycle; coin outputs never high outside PULSE.
REQ-021 DONE: Done=1 one cycle, Residual=remaining, then IDLE.
REQ-022 Latency: Start sampled at edge N -> SELECT at N+1, first pulse at N+2; each coin costs GAP+2 cycles.
REQ-023 Start and Refill ignored while Busy; no queueing.
REQ-024 Counters never underflow: a denomination with count 0 is never selected; remaining never wraps.
REQ-025 Shortfall and Residual hold until the next accepted Start.

Reset
REQ-026 RST: state IDLE, all coin outputs 0, Busy=0, Done=0, Shortfall=0, Residual=0, remaining=0, counters=INIT_COUNT.
REQ-027 RST mid-dispense aborts immediately; no further pulses; in-progress request discarded.

Structure
REQ-028 Shared package vm_pkg holds denomination values (1, 2, 10, 20), price 25, and FSM state encoding, shared with the coin-accept FSM.
REQ-029 One combinational sub-module change_select: inputs remaining and four counts, outputs one-hot pick and its value; FSM and counters stay in change_dispenser.

Verification
REQ-030 Full inventory, Amount=25 -> pulses OneDollar, TenCents, TenCents, FiveCents; Done; Shortfall=0, Residual=0.
REQ-031 Amount=0 -> no pulses; Done two cycles after Start; Shortfall=0.
REQ-032 FiftyCents count 0 (15 dispenses of Amount=10), then Amount=10 -> five TenCents pulses.
REQ-033 FiveCents count 0, Amount=3 -> one TenCents, then Done with Shortfall=1, Residual=1.
REQ-034 Start pulsed during dispense of Amount=40 -> ignored; exactly two OneDollar pulses, one Done.
REQ-035 RST asserted between pulses of Amount=25 -> no further pulses, Busy=0, counters=15.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin denominations in 5-cent units,
// item price, and the change-dispenser FSM state encoding.
package vm_pkg;

    localparam int NUM_DENOM = 4;

    localparam logic [6:0] VAL_DOLLAR = 7'd20;
    localparam logic [6:0] VAL_FIFTY  = 7'd10;
    localparam logic [6:0] VAL_DIME   = 7'd2;
    localparam logic [6:0] VAL_NICKEL = 7'd1;

    localparam logic [6:0] PRICE_UNITS = 7'd25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_PULSE,
        ST_GAP,
        ST_DONE
    } disp_state_t;

    // Index 0 is the largest coin; selection priority follows index order.
    function automatic logic [6:0] denom_value(input int idx);
        case (idx)
            0:       return VAL_DOLLAR;
            1:       return VAL_FIFTY;
            2:       return VAL_DIME;
            default: return VAL_NICKEL;
        endcase
    endfunction

endpackage

// File: rtl/change_select.sv
// Picks the largest coin that still fits in the remaining amount and is in stock.
module change_select
    import vm_pkg::*;
(
    input  logic [6:0]                remaining,
    input  logic [NUM_DENOM-1:0][3:0] counts,
    output logic [NUM_DENOM-1:0]      pick,
    output logic [6:0]                value
);

    logic found;

    always_comb begin
        pick  = '0;
        value = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            if (!found && counts[i] != 4'd0 && denom_value(i) <= remaining) begin
                pick[i] = 1'b1;
                value   = denom_value(i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a requested amount greedily, one coin pulse at a time,
// from four finite coin tubes, reporting any amount it could not cover.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int INIT_COUNT = 15,
    parameter int GAP        = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic [6:0] Amount,
    input  logic       Refill,
    output logic       OneDollar,
    output logic       FiftyCents,
    output logic       TenCents,
    output logic       FiveCents,
    output logic       Busy,
    output logic       Done,
    output logic       Shortfall,
    output logic [6:0] Residual
);

    localparam logic [3:0] INIT_CNT = 4'(INIT_COUNT);
    localparam logic [2:0] GAP_LOAD = 3'(GAP - 1);

    disp_state_t state_reg, state_next;
    logic [6:0]  remaining_reg, remaining_next;
    logic [NUM_DENOM-1:0] pick_reg, pick_next;
    logic [6:0]  value_reg, value_next;
    logic [2:0]  gap_reg, gap_next;
    logic [NUM_DENOM-1:0] coin_reg, coin_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        shortfall_reg, shortfall_next;
    logic [6:0]  residual_reg, residual_next;

    logic        refill_req;
    logic        consume;
    logic [NUM_DENOM-1:0][3:0] counts;
    logic [NUM_DENOM-1:0] sel_pick;
    logic [6:0]  sel_value;

    change_select u_select (
        .remaining (remaining_reg),
        .counts    (counts),
        .pick      (sel_pick),
        .value     (sel_value)
    );

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        pick_next      = pick_reg;
        value_next     = value_reg;
        gap_next       = gap_reg;
        shortfall_next = shortfall_reg;
        residual_next  = residual_reg;
        refill_req     = 1'b0;
        consume        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (Start) begin
                    remaining_next = Amount;
                    shortfall_next = 1'b0;
                    residual_next  = '0;
                    state_next     = ST_SELECT;
                end else if (Refill) begin
                    refill_req = 1'b1;
                end
            end
            ST_SELECT: begin
                if (remaining_reg == '0) begin
                    residual_next = '0;
                    state_next    = ST_DONE;
                end else if (sel_pick != '0) begin
                    pick_next  = sel_pick;
                    value_next = sel_value;
                    state_next = ST_PULSE;
                end else begin
                    shortfall_next = 1'b1;
                    residual_next  = remaining_reg;
                    state_next     = ST_DONE;
                end
            end
            ST_PULSE: begin
                // The selector guaranteed value_reg <= remaining_reg, so no wrap here.
                remaining_next = remaining_reg - value_reg;
                consume        = 1'b1;
                gap_next       = GAP_LOAD;
                state_next     = ST_GAP;
            end
            ST_GAP: begin
                if (gap_reg == '0) begin
                    state_next = ST_SELECT;
                end else begin
                    gap_next = gap_reg - 3'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        coin_next = (state_next == ST_PULSE) ? pick_next : '0;
        busy_next = (state_next != ST_IDLE);
        done_next = (state_next == ST_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            pick_reg      <= '0;
            value_reg     <= '0;
            gap_reg       <= '0;
            coin_reg      <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            shortfall_reg <= 1'b0;
            residual_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            pick_reg      <= pick_next;
            value_reg     <= value_next;
            gap_reg       <= gap_next;
            coin_reg      <= coin_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            shortfall_reg <= shortfall_next;
            residual_reg  <= residual_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DENOM; gi++) begin : g_inv
            logic [3:0] cnt_reg;
            always_ff @(posedge CLK) begin
                if (RST || refill_req) begin
                    cnt_reg <= INIT_CNT;
                end else if (consume && pick_reg[gi]) begin
                    cnt_reg <= cnt_reg - 4'd1;
                end
            end
            assign counts[gi] = cnt_reg;
        end
    endgenerate

    assign OneDollar  = coin_reg[0];
    assign FiftyCents = coin_reg[1];
    assign TenCents   = coin_reg[2];
    assign FiveCents  = coin_reg[3];
    assign Busy       = busy_reg;
    assign Done       = done_reg;
    assign Shortfall  = shortfall_reg;
    assign Residual   = residual_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed-vector bench for change_dispenser; coin sequences are packed 5 bits per coin.
module tb_change_dispenser;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Start;
    logic [6:0] Amount;
    logic       Refill;
    logic       OneDollar, FiftyCents, TenCents, FiveCents;
    logic       Busy, Done, Shortfall;
    logic [6:0] Residual;

    int         n_cmp = 0;
    int         n_bad = 0;

    logic [63:0] seq_code;
    int          n_coins;
    int          coin_cyc[$];
    int          dones;
    int          multi;
    int          done_cyc;

    change_dispenser #(.INIT_COUNT(15), .GAP(1)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Start      (Start),
        .Amount     (Amount),
        .Refill     (Refill),
        .OneDollar  (OneDollar),
        .FiftyCents (FiftyCents),
        .TenCents   (TenCents),
        .FiveCents  (FiveCents),
        .Busy       (Busy),
        .Done       (Done),
        .Shortfall  (Shortfall),
        .Residual   (Residual)
    );

    always #5 CLK = ~CLK;

    // Issues one request from a negedge and records everything until Busy drops.
    task automatic do_request(input logic [6:0] amt, input bit poke, input bit with_refill);
        bit finished = 1'b0;
        seq_code = '0;
        n_coins  = 0;
        coin_cyc.delete();
        dones    = 0;
        multi    = 0;
        done_cyc = -1;
        Amount   = amt;
        Start    = 1'b1;
        Refill   = with_refill;
        @(negedge CLK);
        Start  = 1'b0;
        Refill = 1'b0;
        for (int c = 1; c <= 400 && !finished; c++) begin
            if (int'(OneDollar) + int'(FiftyCents) + int'(TenCents) + int'(FiveCents) > 1) multi++;
            if (OneDollar)  begin seq_code = {seq_code[58:0], 5'd20}; n_coins++; coin_cyc.push_back(c); end
            if (FiftyCents) begin seq_code = {seq_code[58:0], 5'd10}; n_coins++; coin_cyc.push_back(c); end
            if (TenCents)   begin seq_code = {seq_code[58:0], 5'd2};  n_coins++; coin_cyc.push_back(c); end
            if (FiveCents)  begin seq_code = {seq_code[58:0], 5'd1};  n_coins++; coin_cyc.push_back(c); end
            if (Done) begin
                dones++;
                if (done_cyc < 0) done_cyc = c;
            end else if (dones > 0 && !Busy) begin
                finished = 1'b1;
            end
            if (poke) begin
                if (c == 4) begin Start = 1'b1; Amount = 7'd127; end
                else Start = 1'b0;
            end
            if (!finished) @(negedge CLK);
        end
        Start = 1'b0;
        n_cmp++;
        if (!finished) begin
            n_bad++;
            $display("FAIL req_timeout: amount %0d did not complete, dones=%0d busy=%0b", amt, dones, Busy);
        end
        $display("req amount=%0d coins=%0d code=%h done_cyc=%0d shortfall=%0b residual=%0d",
                 amt, n_coins, seq_code, done_cyc, Shortfall, Residual);
    endtask

    task automatic do_refill();
        Refill = 1'b1;
        @(negedge CLK);
        Refill = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1; Start = 1'b0; Refill = 1'b0; Amount = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({OneDollar, FiftyCents, TenCents, FiveCents, Busy, Done, Shortfall} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {OneDollar, FiftyCents, TenCents, FiveCents, Busy, Done, Shortfall});
        end
        n_cmp++;
        if (Residual !== 7'd0) begin n_bad++; $display("FAIL reset_residual: got %0d want 0", Residual); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dut.counts[i] !== 4'd15) begin
                n_bad++;
                $display("FAIL reset_count%0d: got %0d want 15", i, dut.counts[i]);
            end
        end
    endtask

    task automatic test_amount_25();
        do_request(7'd25, 1'b0, 1'b0);
        n_cmp++;
        if (seq_code !== 64'({5'd20, 5'd2, 5'd2, 5'd1})) begin
            n_bad++; $display("FAIL amt25_seq: got %h want %h", seq_code, 64'({5'd20, 5'd2, 5'd2, 5'd1}));
        end
        n_cmp++;
        if (coin_cyc.size() < 2 || coin_cyc[0] != 2 || coin_cyc[1] != 5) begin
            n_bad++; $display("FAIL amt25_timing: got first/second pulse cycles %0d/%0d want 2/5",
                              coin_cyc.size() > 0 ? coin_cyc[0] : -1, coin_cyc.size() > 1 ? coin_cyc[1] : -1);
        end
        n_cmp++;
        if (done_cyc != 14 || dones != 1) begin
            n_bad++; $display("FAIL amt25_done: got cycle %0d count %0d want cycle 14 count 1", done_cyc, dones);
        end
        n_cmp++;
        if (Shortfall !== 1'b0 || Residual !== 7'd0 || multi != 0) begin
            n_bad++; $display("FAIL amt25_status: got sf=%0b res=%0d multi=%0d want 0/0/0", Shortfall, Residual, multi);
        end
    endtask

    task automatic test_amount_zero();
        do_request(7'd0, 1'b0, 1'b0);
        n_cmp++;
        if (n_coins != 0 || done_cyc != 2 || Shortfall !== 1'b0) begin
            n_bad++; $display("FAIL zero_amt: got coins=%0d done_cyc=%0d sf=%0b want 0/2/0", n_coins, done_cyc, Shortfall);
        end
    endtask

    task automatic test_fifty_exhaust();
        int bad_runs = 0;
        do_refill();
        for (int k = 0; k < 15; k++) begin
            do_request(7'd10, 1'b0, 1'b0);
            if (seq_code !== 64'd10 || dones != 1) bad_runs++;
        end
        n_cmp++;
        if (bad_runs != 0) begin n_bad++; $display("FAIL fifty_runs: got %0d bad runs want 0", bad_runs); end
        do_request(7'd10, 1'b0, 1'b0);
        n_cmp++;
        if (seq_code !== 64'({5'd2, 5'd2, 5'd2, 5'd2, 5'd2}) || Shortfall !== 1'b0) begin
            n_bad++; $display("FAIL fifty_empty_seq: got %h sf=%0b want %h sf=0",
                              seq_code, Shortfall, 64'({5'd2, 5'd2, 5'd2, 5'd2, 5'd2}));
        end
        n_cmp++;
        if (dut.counts[1] !== 4'd0 || dut.counts[2] !== 4'd10) begin
            n_bad++; $display("FAIL fifty_counts: got fifty=%0d dime=%0d want 0/10", dut.counts[1], dut.counts[2]);
        end
    endtask

    task automatic test_shortfall();
        int bad_runs = 0;
        do_refill();
        for (int k = 0; k < 15; k++) begin
            do_request(7'd1, 1'b0, 1'b0);
            if (seq_code !== 64'd1) bad_runs++;
        end
        n_cmp++;
        if (bad_runs != 0) begin n_bad++; $display("FAIL nickel_runs: got %0d bad runs want 0", bad_runs); end
        do_request(7'd3, 1'b0, 1'b0);
        n_cmp++;
        if (seq_code !== 64'd2 || dones != 1) begin
            n_bad++; $display("FAIL short_seq: got %h dones=%0d want 2 dones=1", seq_code, dones);
        end
        repeat (5) @(negedge CLK);
        n_cmp++;
        if (Shortfall !== 1'b1 || Residual !== 7'd1) begin
            n_bad++; $display("FAIL short_hold: got sf=%0b res=%0d want 1/1", Shortfall, Residual);
        end
    endtask

    task automatic test_start_with_refill();
        // Nickel tube is empty here; a Start with Refill must not restock it.
        do_request(7'd0, 1'b0, 1'b1);
        n_cmp++;
        if (dut.counts[3] !== 4'd0 || Shortfall !== 1'b0 || Residual !== 7'd0) begin
            n_bad++; $display("FAIL start_refill: got nickel=%0d sf=%0b res=%0d want 0/0/0",
                              dut.counts[3], Shortfall, Residual);
        end
        do_refill();
        n_cmp++;
        if (dut.counts[3] !== 4'd15) begin
            n_bad++; $display("FAIL refill_only: got nickel=%0d want 15", dut.counts[3]);
        end
    endtask

    task automatic test_back_to_back();
        do_refill();
        do_request(7'd40, 1'b1, 1'b0);
        n_cmp++;
        if (seq_code !== 64'({5'd20, 5'd20}) || dones != 1 || multi != 0) begin
            n_bad++; $display("FAIL ignore_start: got %h dones=%0d multi=%0d want %h dones=1 multi=0",
                              seq_code, dones, multi, 64'({5'd20, 5'd20}));
        end
        n_cmp++;
        if (Busy !== 1'b0 || dut.counts[0] !== 4'd13) begin
            n_bad++; $display("FAIL ignore_state: got busy=%0b dollars=%0d want 0/13", Busy, dut.counts[0]);
        end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        do_refill();
        Amount = 7'd25; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_cmp++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_busy: got busy=%0b done=%0b want 0/0", Busy, Done);
        end
        n_cmp++;
        if (dut.counts !== {4'd15, 4'd15, 4'd15, 4'd15}) begin
            n_bad++; $display("FAIL rst_mid_counts: got %h want ffff", dut.counts);
        end
        for (int c = 0; c < 20; c++) begin
            if (OneDollar || FiftyCents || TenCents || FiveCents || Done || Busy) stray++;
            @(negedge CLK);
        end
        n_cmp++;
        if (stray != 0) begin n_bad++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", stray); end
        $display("reset_mid: stray=%0d busy=%0b", stray, Busy);
    endtask

    initial begin
        RST = 1'b1; Start = 1'b0; Refill = 1'b0; Amount = '0;
        @(negedge CLK);
        test_reset();
        test_amount_25();
        test_amount_zero();
        test_fifty_exhaust();
        test_shortfall();
        test_start_with_refill();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
